// File: rtl/mem_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu_if : upstream, data-memory and writeback bundle for mem_lsu         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mem_lsu_if #(
    parameter  int XLEN = 32,
    localparam int SB   = XLEN / 8
);
    // upstream issue side
    logic            i_vld;
    logic            o_rdy;
    logic [2:0]      i_opsel;
    logic            i_ld;
    logic            i_st;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_wdata;
    logic [XLEN-1:0] i_res;
    logic [4:0]      i_rd_waddr;
    logic            i_rd_wen;
    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_inst;

    // data memory port
    logic            o_dmem_req;
    logic            i_dmem_gnt;
    logic [XLEN-1:0] o_dmem_addr;
    logic            o_dmem_wen;
    logic [XLEN-1:0] o_dmem_wdata;
    logic [SB-1:0]   o_dmem_mask;
    logic            i_dmem_rvld;
    logic [XLEN-1:0] i_dmem_rdata;

    // downstream writeback side
    logic            o_vld;
    logic            i_rdy;
    logic [XLEN-1:0] o_wb_data;
    logic [4:0]      o_rd_waddr;
    logic            o_rd_wen;
    logic [XLEN-1:0] o_pc;
    logic [31:0]     o_inst;
    logic            o_misalign;

    modport slave (
        input  i_vld, i_opsel, i_ld, i_st, i_addr, i_wdata, i_res,
        input  i_rd_waddr, i_rd_wen, i_pc, i_inst,
        input  i_dmem_gnt, i_dmem_rvld, i_dmem_rdata, i_rdy,
        output o_rdy, o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_wdata, o_dmem_mask,
        output o_vld, o_wb_data, o_rd_waddr, o_rd_wen, o_pc, o_inst, o_misalign
    );

    modport master (
        output i_vld, i_opsel, i_ld, i_st, i_addr, i_wdata, i_res,
        output i_rd_waddr, i_rd_wen, i_pc, i_inst,
        output i_dmem_gnt, i_dmem_rvld, i_dmem_rdata, i_rdy,
        input  o_rdy, o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_wdata, o_dmem_mask,
        input  o_vld, o_wb_data, o_rd_waddr, o_rd_wen, o_pc, o_inst, o_misalign
    );
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu : single-outstanding load/store unit with aligned byte-lane dmem    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_lsu #(
    parameter  int XLEN = 32,
    localparam int SB   = XLEN / 8
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst,
    mem_lsu_if.slave   bus
);

    localparam int OFFW = $clog2(SB);
    localparam int SHW  = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic              req_q, req_d;
    logic [XLEN-1:0]   daddr_q, daddr_d;
    logic              dwen_q, dwen_d;
    logic [XLEN-1:0]   dwdata_q, dwdata_d;
    logic [SB-1:0]     dmask_q, dmask_d;

    logic              is_ld_q, is_ld_d;
    logic [1:0]        sz_q, sz_d;
    logic              uns_q, uns_d;
    logic [OFFW-1:0]   off_q, off_d;

    logic              vld_q, vld_d;
    logic [XLEN-1:0]   wb_q, wb_d;
    logic [4:0]        rd_waddr_q, rd_waddr_d;
    logic              rd_wen_q, rd_wen_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              mis_q, mis_d;

    logic              w_accept;
    logic              w_mem;
    logic              w_is_ld;
    logic [1:0]        w_sz;
    logic [OFFW-1:0]   w_off;
    logic [OFFW-1:0]   w_lowmask;
    logic              w_misalign;
    logic [SB-1:0]     w_mask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rd_shift;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_shl;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0]   w_ext;

    assign bus.o_rdy = (state_q == IDLE) && !i_rst && (!vld_q || bus.i_rdy);
    assign w_accept  = bus.i_vld && bus.o_rdy;

    // Request decode: a doubleword on a 32-bit datapath collapses to a word.
    always_comb begin
        w_mem      = bus.i_ld || bus.i_st;
        w_is_ld    = bus.i_ld && !bus.i_st;
        w_sz       = (XLEN == 32 && bus.i_opsel[1:0] == 2'b11) ? 2'b10 : bus.i_opsel[1:0];
        w_off      = bus.i_addr[OFFW-1:0];
        w_lowmask  = OFFW'((1 << w_sz) - 1);
        w_misalign = |(w_off & w_lowmask);
        w_mask     = SB'(((1 << (1 << w_sz)) - 1) << w_off);
        w_wdata    = bus.i_wdata << {w_off, 3'b000};
    end

    // Load extraction: move the addressed bytes to the top, then shift back
    // down logically or arithmetically to zero- or sign-extend.
    always_comb begin
        w_rd_shift = bus.i_dmem_rdata >> {off_q, 3'b000};
        w_shamt    = SHW'(XLEN - (8 << sz_q));
        w_shl      = w_rd_shift << w_shamt;
        w_sext     = $signed(w_shl) >>> w_shamt;
        w_ext      = uns_q ? (w_shl >> w_shamt) : w_sext;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        daddr_d    = daddr_q;
        dwen_d     = dwen_q;
        dwdata_d   = dwdata_q;
        dmask_d    = dmask_q;
        is_ld_d    = is_ld_q;
        sz_d       = sz_q;
        uns_d      = uns_q;
        off_d      = off_q;
        vld_d      = vld_q;
        wb_d       = wb_q;
        rd_waddr_d = rd_waddr_q;
        rd_wen_d   = rd_wen_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        mis_d      = mis_q;

        case (state_q)
            IDLE: begin
                if (vld_q && bus.i_rdy) begin
                    vld_d = 1'b0;
                end
                if (w_accept) begin
                    rd_waddr_d = bus.i_rd_waddr;
                    pc_d       = bus.i_pc;
                    inst_d     = bus.i_inst;
                    mis_d      = 1'b0;
                    wb_d       = '0;
                    if (!w_mem) begin
                        vld_d    = 1'b1;
                        wb_d     = bus.i_res;
                        rd_wen_d = bus.i_rd_wen;
                    end else if (w_misalign) begin
                        vld_d    = 1'b1;
                        mis_d    = 1'b1;
                        rd_wen_d = 1'b0;
                    end else begin
                        // Sideband parks in the (now empty) output register
                        // until the access completes.
                        vld_d    = 1'b0;
                        rd_wen_d = bus.i_rd_wen && w_is_ld;
                        state_d  = REQ;
                        req_d    = 1'b1;
                        daddr_d  = {bus.i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        dwen_d   = !w_is_ld;
                        dwdata_d = w_wdata;
                        dmask_d  = w_mask;
                        is_ld_d  = w_is_ld;
                        sz_d     = w_sz;
                        uns_d    = bus.i_opsel[2];
                        off_d    = w_off;
                    end
                end
            end

            REQ: begin
                if (bus.i_dmem_gnt) begin
                    req_d = 1'b0;
                    if (is_ld_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                        vld_d   = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (bus.i_dmem_rvld) begin
                    wb_d    = w_ext;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            daddr_q    <= '0;
            dwen_q     <= 1'b0;
            dwdata_q   <= '0;
            dmask_q    <= '0;
            is_ld_q    <= 1'b0;
            sz_q       <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= '0;
            vld_q      <= 1'b0;
            wb_q       <= '0;
            rd_waddr_q <= 5'd0;
            rd_wen_q   <= 1'b0;
            pc_q       <= '0;
            inst_q     <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            daddr_q    <= daddr_d;
            dwen_q     <= dwen_d;
            dwdata_q   <= dwdata_d;
            dmask_q    <= dmask_d;
            is_ld_q    <= is_ld_d;
            sz_q       <= sz_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            vld_q      <= vld_d;
            wb_q       <= wb_d;
            rd_waddr_q <= rd_waddr_d;
            rd_wen_q   <= rd_wen_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.o_dmem_req   = req_q;
    assign bus.o_dmem_addr  = daddr_q;
    assign bus.o_dmem_wen   = dwen_q;
    assign bus.o_dmem_wdata = dwdata_q;
    assign bus.o_dmem_mask  = dmask_q;

    assign bus.o_vld      = vld_q;
    assign bus.o_wb_data  = wb_q;
    assign bus.o_rd_waddr = rd_waddr_q;
    assign bus.o_rd_wen   = rd_wen_q;
    assign bus.o_pc       = pc_q;
    assign bus.o_inst     = inst_q;
    assign bus.o_misalign = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_lsu : scoreboard bench for mem_lsu with a simple dmem responder      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mem_lsu;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lsu_if #(.XLEN(XLEN)) bus ();
    mem_lsu #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    out_t  exp_q[$];
    dreq_t dexp_q[$];
    int    checks = 0;
    int    errors = 0;

    int          gnt_delay  = 0;
    int          rvld_delay = 1;
    logic        glitch     = 1'b0;
    logic [31:0] rd_val     = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // dmem responder: grant after gnt_delay cycles, read data rvld_delay later
    initial begin
        int wcnt = 0;
        int pend = 0;
        bus.i_dmem_gnt   = 1'b0;
        bus.i_dmem_rvld  = 1'b0;
        bus.i_dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.i_dmem_gnt  = 1'b0;
            bus.i_dmem_rvld = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.i_dmem_rvld  = 1'b1;
                    bus.i_dmem_rdata = rd_val;
                end
            end else if (bus.o_dmem_req) begin
                if (wcnt < gnt_delay) begin
                    wcnt++;
                end else begin
                    bus.i_dmem_gnt = 1'b1;
                    wcnt = 0;
                    if (!bus.o_dmem_wen) pend = rvld_delay;
                    if (glitch) begin
                        bus.i_dmem_rvld  = 1'b1;
                        bus.i_dmem_rdata = 32'h5A5A_5A5A;
                    end
                end
            end
        end
    end

    // monitor: handshake scoreboards plus hold-stability checks
    initial begin
        logic  p_req = 1'b0, p_gnt = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
        dreq_t p_d, d;
        out_t  p_o, e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                p_req = 1'b0;
                p_vld = 1'b0;
            end else begin
                if (p_req && !p_gnt) begin
                    check("req_hold",   64'(bus.o_dmem_req),   64'(1'b1));
                    check("addr_hold",  64'(bus.o_dmem_addr),  64'(p_d.addr));
                    check("wdata_hold", 64'(bus.o_dmem_wdata), 64'(p_d.wdata));
                    check("mask_hold",  64'(bus.o_dmem_mask),  64'(p_d.mask));
                end
                if (bus.o_dmem_req && bus.i_dmem_gnt) begin
                    if (dexp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dmem_req: got addr %h expected none", bus.o_dmem_addr);
                    end else begin
                        d = dexp_q.pop_front();
                        check("dmem_addr",  64'(bus.o_dmem_addr),  64'(d.addr));
                        check("dmem_wen",   64'(bus.o_dmem_wen),   64'(d.wen));
                        check("dmem_wdata", 64'(bus.o_dmem_wdata), 64'(d.wdata));
                        check("dmem_mask",  64'(bus.o_dmem_mask),  64'(d.mask));
                    end
                end
                if (p_vld && !p_rdy) begin
                    check("vld_hold", 64'(bus.o_vld),     64'(1'b1));
                    check("wb_hold",  64'(bus.o_wb_data), 64'(p_o.wb));
                    check("pc_hold",  64'(bus.o_pc),      64'(p_o.pc));
                end
                if (bus.o_vld && bus.i_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got wb %h expected none", bus.o_wb_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_data",  64'(bus.o_wb_data),  64'(e.wb));
                        check("rd_waddr", 64'(bus.o_rd_waddr), 64'(e.rd));
                        check("rd_wen",   64'(bus.o_rd_wen),   64'(e.wen));
                        check("pc",       64'(bus.o_pc),       64'(e.pc));
                        check("inst",     64'(bus.o_inst),     64'(e.inst));
                        check("misalign", 64'(bus.o_misalign), 64'(e.mis));
                    end
                end
                p_req = bus.o_dmem_req;
                p_gnt = bus.i_dmem_gnt;
                p_d   = '{bus.o_dmem_addr, bus.o_dmem_wen, bus.o_dmem_wdata, bus.o_dmem_mask};
                p_vld = bus.o_vld;
                p_rdy = bus.i_rdy;
                p_o   = '{bus.o_wb_data, bus.o_rd_waddr, bus.o_rd_wen, bus.o_pc, bus.o_inst, bus.o_misalign};
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] res,
                         input logic [4:0] rd, input logic wen, input logic [31:0] pc);
        bus.i_vld      = 1'b1;
        bus.i_ld       = ld;
        bus.i_st       = st;
        bus.i_opsel    = op;
        bus.i_addr     = addr;
        bus.i_wdata    = wdata;
        bus.i_res      = res;
        bus.i_rd_waddr = rd;
        bus.i_rd_wen   = wen;
        bus.i_pc       = pc;
        bus.i_inst     = pc ^ 32'h0000_0033;
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] res,
                         input logic [4:0] rd, input logic wen, input logic [31:0] pc);
        int n = 0;
        drive(ld, st, op, addr, wdata, res, rd, wen, pc);
        #1;
        while (!bus.o_rdy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.o_rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_rdy 0 expected 1");
        end
        @(negedge clk);
        bus.i_vld = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic load_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] daddr, input logic [3:0] mask, input logic [31:0] wb);
        rd_val = rdata;
        dexp_q.push_back('{daddr, 1'b0, 32'd0, mask});
        exp_q.push_back('{wb, 5'd10, 1'b1, addr + 32'h1000, (addr + 32'h1000) ^ 32'h33, 1'b0});
        issue(1'b1, 1'b0, op, addr, 32'd0, 32'd0, 5'd10, 1'b1, addr + 32'h1000);
        settle();
    endtask

    task automatic store_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] daddr, input logic [3:0] mask, input logic [31:0] dwdata);
        dexp_q.push_back('{daddr, 1'b1, dwdata, mask});
        exp_q.push_back('{32'd0, 5'd11, 1'b0, addr + 32'h2000, (addr + 32'h2000) ^ 32'h33, 1'b0});
        issue(1'b0, 1'b1, op, addr, wdata, 32'd0, 5'd11, 1'b1, addr + 32'h2000);
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        bus.i_rdy = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        bus.i_vld = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdy",      64'(bus.o_rdy),      64'(1'b0));
        check("rst_vld",      64'(bus.o_vld),      64'(1'b0));
        check("rst_req",      64'(bus.o_dmem_req), 64'(1'b0));
        check("rst_wen",      64'(bus.o_rd_wen),   64'(1'b0));
        check("rst_misalign", 64'(bus.o_misalign), 64'(1'b0));
        check("rst_wb",       64'(bus.o_wb_data),  64'(32'd0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // non-memory op, latency 1
        exp_q.push_back('{32'h1234, 5'd5, 1'b1, 32'h1000, 32'h1000 ^ 32'h33, 1'b0});
        issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h1234, 5'd5, 1'b1, 32'h1000);
        #1;
        check("nonmem_latency", 64'(bus.o_vld), 64'(1'b1));
        check("nonmem_rdy",     64'(bus.o_rdy), 64'(1'b1));
        settle();

        // LB 0x103 with a stray rvld in the grant cycle
        glitch = 1'b1;
        rd_val = 32'h80FF_FFFF;
        dexp_q.push_back('{32'h100, 1'b0, 32'd0, 4'h8});
        exp_q.push_back('{32'hFFFF_FF80, 5'd10, 1'b1, 32'h1103, 32'h1103 ^ 32'h33, 1'b0});
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'd0, 5'd10, 1'b1, 32'h1103);
        #1;
        check("lb_req",   64'(bus.o_dmem_req), 64'(1'b1));
        check("lb_vld_c1", 64'(bus.o_vld),     64'(1'b0));
        @(negedge clk);
        #1;
        check("lb_vld_c2", 64'(bus.o_vld), 64'(1'b0));
        @(negedge clk);
        #1;
        check("lb_latency", 64'(bus.o_vld), 64'(1'b1));
        glitch = 1'b0;
        settle();

        // SH 0x102 with delayed grant
        gnt_delay = 3;
        dexp_q.push_back('{32'h100, 1'b1, 32'hABCD_0000, 4'hC});
        exp_q.push_back('{32'd0, 5'd6, 1'b0, 32'h3000, 32'h3000 ^ 32'h33, 1'b0});
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'd0, 5'd6, 1'b1, 32'h3000);
        #1;
        n = 0;
        while (!(bus.o_dmem_req && bus.i_dmem_gnt) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("sh_gnt_wait", 64'(n), 64'(3));
        check("sh_vld_at_gnt", 64'(bus.o_vld), 64'(1'b0));
        @(negedge clk);
        #1;
        check("sh_vld_after_gnt", 64'(bus.o_vld),    64'(1'b1));
        check("sh_rd_wen",        64'(bus.o_rd_wen), 64'(1'b0));
        gnt_delay = 0;
        settle();

        // misaligned LW
        exp_q.push_back('{32'd0, 5'd8, 1'b0, 32'h4000, 32'h4000 ^ 32'h33, 1'b1});
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 5'd8, 1'b1, 32'h4000);
        #1;
        check("mis_req",  64'(bus.o_dmem_req), 64'(1'b0));
        check("mis_flag", 64'(bus.o_misalign), 64'(1'b1));
        settle();

        // further directed loads / stores
        load_op(3'b100, 32'h102, 32'h00AB_0000, 32'h100, 4'h4, 32'h0000_00AB);
        load_op(3'b101, 32'h106, 32'h8001_F00D, 32'h104, 4'hC, 32'h0000_8001);
        load_op(3'b001, 32'h100, 32'h1234_8765, 32'h100, 4'h3, 32'hFFFF_8765);
        load_op(3'b010, 32'h200, 32'hDEAD_BEEF, 32'h200, 4'hF, 32'hDEAD_BEEF);
        load_op(3'b011, 32'h104, 32'hCAFE_F00D, 32'h104, 4'hF, 32'hCAFE_F00D);
        load_op(3'b110, 32'h108, 32'h8765_4321, 32'h108, 4'hF, 32'h8765_4321);
        store_op(3'b000, 32'h101, 32'h1234_5678, 32'h100, 4'h2, 32'h3456_7800);
        store_op(3'b010, 32'h208, 32'hDEAD_BEEF, 32'h208, 4'hF, 32'hDEAD_BEEF);
        exp_q.push_back('{32'd0, 5'd9, 1'b0, 32'h5000, 32'h5000 ^ 32'h33, 1'b1});
        issue(1'b0, 1'b1, 3'b001, 32'h101, 32'hFFFF, 32'd0, 5'd9, 1'b1, 32'h5000);
        settle();

        // downstream stall
        bus.i_rdy = 1'b0;
        exp_q.push_back('{32'hA1, 5'd1, 1'b1, 32'h6000, 32'h6000 ^ 32'h33, 1'b0});
        exp_q.push_back('{32'hB2, 5'd2, 1'b1, 32'h6004, 32'h6004 ^ 32'h33, 1'b0});
        issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'hA1, 5'd1, 1'b1, 32'h6000);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'hB2, 5'd2, 1'b1, 32'h6004);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_rdy", 64'(bus.o_rdy),     64'(1'b0));
            check("stall_vld", 64'(bus.o_vld),     64'(1'b1));
            check("stall_wb",  64'(bus.o_wb_data), 64'(32'hA1));
            @(negedge clk);
        end
        bus.i_rdy = 1'b1;
        #1;
        check("stall_resume", 64'(bus.o_rdy), 64'(1'b1));
        @(negedge clk);
        bus.i_vld = 1'b0;
        settle();

        // reset while waiting for read data, then a late rvld
        rvld_delay = 6;
        dexp_q.push_back('{32'h300, 1'b0, 32'd0, 4'hF});
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd7, 1'b1, 32'h7000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rdy", 64'(bus.o_rdy),      64'(1'b0));
        check("midrst_vld", 64'(bus.o_vld),      64'(1'b0));
        check("midrst_req", 64'(bus.o_dmem_req), 64'(1'b0));
        check("midrst_pc",  64'(bus.o_pc),       64'(32'd0));
        check("midrst_inst", 64'(bus.o_inst),    64'(32'd0));
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("postrst_vld", 64'(bus.o_vld), 64'(1'b0));
        check("postrst_rdy", 64'(bus.o_rdy), 64'(1'b1));
        rvld_delay = 1;
        @(negedge clk);

        check("exp_q_empty",  64'(exp_q.size()),  64'(0));
        check("dexp_q_empty", 64'(dexp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, meaning data/address width; legal values 32 and 64.
REQ-002 Parameter SB = XLEN/8 (derived), meaning byte-strobe width.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_vld  in  1  upstream instruction valid.
REQ-006 o_rdy  out  1  stage can accept; transfer occurs when i_vld && o_rdy.
REQ-007 i_opsel  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 i_ld, i_st  in  1 each  load / store; both 0 means non-memory op.
REQ-009 i_addr, i_wdata, i_res  in  XLEN each  effective address, store data, ALU result.
REQ-010 i_rd_waddr, i_rd_wen  in  5, 1  destination register and write enable.
REQ-011 i_pc, i_inst  in  XLEN, 32  sideband carried to output.
REQ-012 o_dmem_req, i_dmem_gnt  out/in  1, 1  request / grant handshake.
REQ-013 o_dmem_addr, o_dmem_wen, o_dmem_wdata, o_dmem_mask  out  XLEN, 1, XLEN, SB  aligned address, write, lane-shifted data, byte strobes.
REQ-014 i_dmem_rvld, i_dmem_rdata  in  1, XLEN  read response.
REQ-015 o_vld, i_rdy  out/in  1, 1  downstream handshake.
REQ-016 o_wb_data, o_rd_waddr, o_rd_wen, o_pc, o_inst, o_misalign  out  XLEN, 5, 1, XLEN, 32, 1  writeback result and sideband.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT; o_rdy SHALL be 1 only when state=IDLE, i_rst=0 and (o_vld=0 or i_rdy=1).
REQ-018 Non-memory op accepted: output register SHALL load next edge (o_wb_data=i_res, o_vld=1), state stays IDLE; latency 1.
REQ-019 Access size: B=1, H=2, W=4, D=8 bytes; D with XLEN=32 SHALL be treated as W.
REQ-020 Misaligned (addr mod size != 0) memory op: no dmem request, output next edge with o_misalign=1, o_rd_wen=0.
REQ-021 Aligned memory op accepted: captured, state -> REQ; o_dmem_addr = addr with low log2(SB) bits cleared; mask = size ones shifted by byte offset; wdata = store data shifted left 8*offset.
REQ-022 In REQ, o_dmem_req=1 and all o_dmem_* SHALL stay stable until i_dmem_gnt=1.
REQ-023 Store grant: state -> IDLE, o_vld=1 next edge, o_rd_wen=0.
REQ-024 Load grant: state -> WAIT; i_dmem_rvld in the grant cycle SHALL be ignored.
REQ-025 WAIT + i_dmem_rvld: o_wb_data = rdata shifted right 8*offset, truncated to size, sign-extended (B/H/W) or zero-extended (BU/HU/WU; WU=W when XLEN=32); o_vld=1 next edge; state -> IDLE.
REQ-026 i_dmem_rvld in IDLE or REQ SHALL be ignored.
REQ-027 o_vld SHALL hold with all outputs stable until i_rdy=1; o_vld clears on transfer unless a new item loads the same edge.
REQ-028 Output register is guaranteed empty during REQ/WAIT (entry requires drain); load data is never dropped.
REQ-029 o_dmem_req SHALL be 0 outside REQ; no more than one request outstanding.

Reset
REQ-030 While i_rst=1: state=IDLE, o_vld=0, o_dmem_req=0, o_rdy=0, o_misalign=0, o_rd_wen=0, o_wb_data/o_pc/o_inst=0.
REQ-031 Reset mid-REQ or mid-WAIT SHALL abort the access; a later i_dmem_rvld SHALL be ignored.

Verification
REQ-032 Non-mem op, i_res=0x1234, i_rdy=1 -> o_vld=1 next cycle, o_wb_data=0x1234, o_rdy stays 1.
REQ-033 LB addr 0x103, rdata 0x80FF_FFFF, gnt immediate, rvld one cycle later -> o_dmem_addr=0x100, mask=0x8, o_wb_data=0xFFFF_FF80 three cycles after accept.
REQ-034 SH addr 0x102, wdata 0xABCD, gnt delayed 3 cycles -> req held with stable addr 0x100, mask=0xC, wdata=0xABCD_0000; o_vld 1 cycle after gnt, o_rd_wen=0.
REQ-035 LW addr 0x101 -> no o_dmem_req, o_misalign=1, o_rd_wen=0 next cycle.
REQ-036 i_rdy=0 for 4 cycles with o_vld=1 -> outputs stable, o_rdy=0, no new accept; accept resumes in the i_rdy=1 cycle.
REQ-037 Reset asserted in WAIT, released, spurious rvld -> o_vld stays 0, state IDLE, o_rdy=1.
